// File: rtl/aes_pkg.sv
// Shared AES definitions: decrypt FSM states, block geometry and GF(2^8) arithmetic.
// The GF helpers are also used by the encrypt-side MixColumns.
package aes_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_INV_SHIFT,
      S_INV_SUB,
      S_ADD_KEY,
      S_INV_MIX,
      S_DONE
   } state_t;

   localparam int AES_BYTES  = 16;
   localparam int AES_ROUNDS = 10;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Shift-and-add multiply, reduced modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = '0;
      p   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

endpackage

// File: rtl/inv_sub_bytes.sv
// Combinational AES inverse S-box: one byte in, one byte out.
module inv_sub_bytes (
   input  logic [7:0] value,
   output logic [7:0] result
);

   // Row-major table, entry 0x00 in the top byte.
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   assign result = INV_SBOX[11'd2047 - {value, 3'b000} -: 8];

endmodule

// File: rtl/aes_decrypt.sv
// Byte-serial AES-128 inverse cipher. Ciphertext and round keys stream in a byte
// at a time; the 128-bit working state rotates through a single S-box lane.
module aes_decrypt
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = AES_ROUNDS
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [7:0]   in,
   input  logic         in_valid,
   input  logic [7:0]   key,
   input  logic         key_valid,
   output logic         key_ready,
   output logic [3:0]   key_round,
   output logic         busy,
   output logic         done,
   output logic [127:0] message
);

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
   localparam logic [3:0] LAST_BYTE  = 4'(AES_BYTES - 1);

   state_t     state;
   logic [3:0] round;
   logic [3:0] cnt;
   logic [7:0] sub_out;

   // Byte index b = r + 4c sits at message[127-8b -: 8]; row r rotates right by r.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r) & 3)) -: 8];
      return o;
   endfunction

   function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

   inv_sub_bytes u_inv_sub (
      .value  (message[127:120]),
      .result (sub_out)
   );

   // Handshake: a key byte transfers on a rising edge where key_ready && key_valid
   // (in LOAD additionally in_valid); a low valid simply stalls that byte.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         message   <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         key_ready <= 1'b0;
         key_round <= LAST_ROUND;
         round     <= LAST_ROUND;
         cnt       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_LOAD;
                  round     <= LAST_ROUND;
                  cnt       <= '0;
                  busy      <= 1'b1;
                  key_ready <= 1'b1;
                  key_round <= LAST_ROUND;
               end
            end
            S_LOAD: begin
               if (in_valid && key_valid) begin
                  message <= {message[119:0], in ^ key};
                  cnt     <= cnt + 4'd1;
                  if (cnt == LAST_BYTE) begin
                     state     <= S_INV_SHIFT;
                     round     <= LAST_ROUND - 4'd1;
                     key_ready <= 1'b0;
                  end
               end
            end
            S_INV_SHIFT: begin
               message <= inv_shift_rows(message);
               cnt     <= '0;
               state   <= S_INV_SUB;
            end
            S_INV_SUB: begin
               message <= {message[119:0], sub_out};
               cnt     <= cnt + 4'd1;
               if (cnt == LAST_BYTE) begin
                  state     <= S_ADD_KEY;
                  key_ready <= 1'b1;
                  key_round <= round;
               end
            end
            S_ADD_KEY: begin
               if (key_valid) begin
                  message <= {message[119:0], message[127:120] ^ key};
                  cnt     <= cnt + 4'd1;
                  if (cnt == LAST_BYTE) begin
                     key_ready <= 1'b0;
                     if (round == 4'd0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end else begin
                        state <= S_INV_MIX;
                     end
                  end
               end
            end
            S_INV_MIX: begin
               message <= {message[95:0], inv_mix_column(message[127:96])};
               cnt     <= cnt + 4'd1;
               if (cnt == 4'd3) begin
                  cnt   <= '0;
                  round <= round - 4'd1;
                  state <= S_INV_SHIFT;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_decrypt.sv
// Bench for aes_decrypt: FIPS-197 vectors, stalls, aborts and random blocks checked
// against an arithmetic AES model (tables derived from GF(2^8) inversion).
module tb_aes_decrypt;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [7:0]   in = 8'h00;
   logic         in_valid = 1'b0;
   logic [7:0]   key = 8'h00;
   logic         key_valid = 1'b0;
   logic         key_ready;
   logic [3:0]   key_round;
   logic         busy;
   logic         done;
   logic [127:0] message;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0]   sbox  [256];
   logic [7:0]   isbox [256];
   logic [127:0] rk    [11];
   logic [127:0] exp_q [$];

   int cfg_in_stall, cfg_in_stall_at, cfg_key_stall, cfg_key_stall_round;
   int cfg_start_at, cfg_abort_at;
   bit cfg_rand;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   aes_decrypt #(.NUM_ROUNDS(10)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .in        (in),
      .in_valid  (in_valid),
      .key       (key),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_round (key_round),
      .busy      (busy),
      .done      (done),
      .message   (message)
   );

   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic       hi;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = a << 1;
         if (hi) a = a ^ 8'h1b;
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   task automatic build_tables();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0)
            for (int b = 1; b < 256; b++)
               if (gmul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox[x]  = s;
         isbox[s] = 8'(x);
      end
   endtask

   task automatic expand_key(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] inv_cipher(input logic [127:0] ct);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ rk[10][127 - 8*i -: 8];
      for (int rnd = 9; rnd >= 0; rnd--) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r + 4*c] = s[r + 4*((c - r + 4) % 4)];
         for (int i = 0; i < 16; i++) s[i] = isbox[t[i]] ^ rk[rnd][127 - 8*i -: 8];
         if (rnd > 0)
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
               s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
               s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
               s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
            end
      end
      for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
      return o;
   endfunction

   // ---------------- driver ----------------
   task automatic set_defaults();
      cfg_in_stall = 0; cfg_in_stall_at = 0;
      cfg_key_stall = 0; cfg_key_stall_round = 5;
      cfg_start_at = -1; cfg_abort_at = -1; cfg_rand = 0;
   endtask

   // Cycle 0 presents start; returns the cycle done was seen (-1 if never).
   task automatic run_decrypt(input logic [127:0] ct, output int done_cyc, output int stalls,
                              output int kr_bad, output logic [127:0] pt);
      int kidx, in_rem, key_rem;
      bit key_stalling, in_load, add_key, iv, kv;
      done_cyc = -1; stalls = 0; kr_bad = 0; pt = '0;
      kidx = 0; in_rem = cfg_in_stall; key_rem = cfg_key_stall; key_stalling = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clock);
         if (cyc == cfg_abort_at) return;
         if (done === 1'b1) begin
            done_cyc = cyc; pt = message;
            start = 0; in_valid = 0; key_valid = 0;
            break;
         end
         start   = (cyc == 0) || (cyc == cfg_start_at);
         in_load = (key_ready === 1'b1) && (key_round === 4'd10);
         add_key = (key_ready === 1'b1) && !in_load;
         iv = 1; kv = 1;
         if (cfg_rand) begin
            iv = ($urandom_range(0, 3) != 0);
            kv = ($urandom_range(0, 3) != 0);
         end
         if (in_load && kidx == cfg_in_stall_at && in_rem > 0) begin
            iv = 0; in_rem--;
         end
         if (add_key && key_round == 4'(cfg_key_stall_round) && kidx == 7 && key_rem > 0)
            key_stalling = 1;
         if (key_stalling && key_rem > 0) begin
            kv = 0; key_rem--;
            if (key_round !== 4'(cfg_key_stall_round)) kr_bad++;
         end
         in  = ct[127 - 8*kidx -: 8];
         key = (key_round <= 4'd10) ? rk[key_round][127 - 8*kidx -: 8] : 8'h00;
         in_valid = iv; key_valid = kv;
         if (in_load) begin
            if (iv && kv) kidx = (kidx + 1) % 16; else stalls++;
         end else if (add_key) begin
            if (kv) kidx = (kidx + 1) % 16; else stalls++;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #3 reset = 1;
      #1;
      n_cmp++; if (message !== 128'h0) begin n_fail++; $display("FAIL reset_message got=%h exp=0", message); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL reset_key_ready got=%b exp=0", key_ready); end
      n_cmp++; if (key_round !== 4'd10) begin n_fail++; $display("FAIL reset_key_round got=%0d exp=10", key_round); end
      @(posedge clock); @(posedge clock);
      @(negedge clock); reset = 0;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_fips_c1();
      int dc, st, kb; logic [127:0] pt;
      set_defaults(); expand_key(C1_KEY);
      exp_q.push_back(inv_cipher(C1_CT));
      run_decrypt(C1_CT, dc, st, kb, pt);
      n_cmp++; if (dc != 383) begin n_fail++; $display("FAIL c1_done_cycle got=%0d exp=383", dc); end
      n_cmp++; if (pt !== C1_PT) begin n_fail++; $display("FAIL c1_plaintext got=%h exp=%h", pt, C1_PT); end
      n_cmp++; if (pt !== exp_q[0]) begin n_fail++; $display("FAIL c1_model got=%h exp=%h", pt, exp_q[0]); end
      void'(exp_q.pop_front());
      @(negedge clock);
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL c1_idle_busy got=%b exp=0", busy); end
      n_cmp++; if (key_round !== 4'd0) begin n_fail++; $display("FAIL c1_key_round_hold got=%0d exp=0", key_round); end
      n_cmp++; if (message !== C1_PT) begin n_fail++; $display("FAIL c1_message_hold got=%h exp=%h", message, C1_PT); end
   endtask

   task automatic test_fips_b();
      int dc, st, kb; logic [127:0] pt;
      set_defaults(); expand_key(B_KEY);
      run_decrypt(B_CT, dc, st, kb, pt);
      n_cmp++; if (dc != 383) begin n_fail++; $display("FAIL b_done_cycle got=%0d exp=383", dc); end
      n_cmp++; if (pt !== B_PT) begin n_fail++; $display("FAIL b_plaintext got=%h exp=%h", pt, B_PT); end
      repeat (2) @(negedge clock);
   endtask

   task automatic test_stalls();
      int dc, st, kb; logic [127:0] pt;
      set_defaults(); expand_key(C1_KEY);
      cfg_in_stall = 3; cfg_in_stall_at = 5; cfg_key_stall = 5; cfg_key_stall_round = 5;
      run_decrypt(C1_CT, dc, st, kb, pt);
      n_cmp++; if (dc != 391) begin n_fail++; $display("FAIL stall_done_cycle got=%0d exp=391", dc); end
      n_cmp++; if (st != 8) begin n_fail++; $display("FAIL stall_count got=%0d exp=8", st); end
      n_cmp++; if (kb != 0) begin n_fail++; $display("FAIL stall_key_round bad_cycles=%0d exp=0", kb); end
      n_cmp++; if (pt !== C1_PT) begin n_fail++; $display("FAIL stall_plaintext got=%h exp=%h", pt, C1_PT); end
      repeat (2) @(negedge clock);
   endtask

   task automatic test_start_while_busy();
      int dc, st, kb; logic [127:0] pt;
      set_defaults(); expand_key(C1_KEY);
      cfg_start_at = 100;
      run_decrypt(C1_CT, dc, st, kb, pt);
      n_cmp++; if (dc != 383) begin n_fail++; $display("FAIL busy_start_done_cycle got=%0d exp=383", dc); end
      n_cmp++; if (pt !== C1_PT) begin n_fail++; $display("FAIL busy_start_plaintext got=%h exp=%h", pt, C1_PT); end
      repeat (2) @(negedge clock);
   endtask

   task automatic test_reset_mid_run();
      int dc, st, kb; int seen_done; logic [127:0] pt;
      set_defaults(); expand_key(C1_KEY);
      cfg_abort_at = 220;
      run_decrypt(C1_CT, dc, st, kb, pt);
      reset = 1;
      #1;
      n_cmp++; if (message !== 128'h0) begin n_fail++; $display("FAIL abort_message got=%h exp=0", message); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
      n_cmp++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL abort_key_ready got=%b exp=0", key_ready); end
      n_cmp++; if (key_round !== 4'd10) begin n_fail++; $display("FAIL abort_key_round got=%0d exp=10", key_round); end
      seen_done = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         if (done !== 1'b0) seen_done++;
      end
      reset = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (done !== 1'b0) seen_done++;
      end
      n_cmp++; if (seen_done != 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", seen_done); end
      set_defaults();
      run_decrypt(C1_CT, dc, st, kb, pt);
      n_cmp++; if (dc != 383) begin n_fail++; $display("FAIL abort_rerun_done got=%0d exp=383", dc); end
      n_cmp++; if (pt !== C1_PT) begin n_fail++; $display("FAIL abort_rerun_plaintext got=%h exp=%h", pt, C1_PT); end
      repeat (2) @(negedge clock);
   endtask

   task automatic test_back_to_back();
      int dc, st, kb; logic [127:0] pt1, pt2, ct2;
      set_defaults(); expand_key(C1_KEY);
      run_decrypt(C1_CT, dc, st, kb, pt1);
      n_cmp++; if (pt1 !== C1_PT) begin n_fail++; $display("FAIL b2b_first got=%h exp=%h", pt1, C1_PT); end
      @(negedge clock);
      start = 1; in_valid = 0; key_valid = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         start = 0;
         n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got=%b exp=1", busy); end
         n_cmp++; if (message !== C1_PT) begin n_fail++; $display("FAIL b2b_hold got=%h exp=%h", message, C1_PT); end
      end
      ct2 = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(inv_cipher(ct2));
      run_decrypt(ct2, dc, st, kb, pt2);
      n_cmp++; if (dc != 382) begin n_fail++; $display("FAIL b2b_done_cycle got=%0d exp=382", dc); end
      n_cmp++; if (pt2 !== exp_q[0]) begin n_fail++; $display("FAIL b2b_second got=%h exp=%h", pt2, exp_q[0]); end
      void'(exp_q.pop_front());
      repeat (2) @(negedge clock);
   endtask

   task automatic test_random();
      int dc, st, kb; logic [127:0] pt, ct, k;
      for (int n = 0; n < 4; n++) begin
         set_defaults(); cfg_rand = 1;
         k  = {$urandom, $urandom, $urandom, $urandom};
         ct = {$urandom, $urandom, $urandom, $urandom};
         expand_key(k);
         exp_q.push_back(inv_cipher(ct));
         run_decrypt(ct, dc, st, kb, pt);
         n_cmp++; if (dc != 383 + st) begin n_fail++; $display("FAIL rand%0d_done_cycle got=%0d exp=%0d", n, dc, 383 + st); end
         n_cmp++; if (pt !== exp_q[0]) begin n_fail++; $display("FAIL rand%0d_plaintext got=%h exp=%h", n, pt, exp_q[0]); end
         void'(exp_q.pop_front());
         repeat ($urandom_range(1, 4)) @(negedge clock);
      end
   endtask

   initial begin
      build_tables();
      test_reset();
      test_fips_c1();
      test_fips_b();
      test_stalls();
      test_start_while_busy();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
